// File: rtl/yrv_uart_pkg.sv
// Shared types for the YRV auxiliary UART: receiver FSM states, parity modes, FIFO entry layout.
// Pure declarations and one combinational helper; no latency, no flow control.
package yrv_uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Entries are sized for the widest character so the FIFO layout never changes.
  localparam int RX_MAX_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef struct packed {
    logic [RX_MAX_BITS-1:0] data;
    logic                   perr;
    logic                   ferr;
  } rx_entry_t;

  // ones_odd is the XOR of the data bits and the received parity bit.
  function automatic logic parity_fail(input int mode, input logic ones_odd);
    logic fail;
    fail = 1'b0;
    if (mode == PARITY_EVEN) fail = ones_odd;
    else if (mode == PARITY_ODD) fail = ~ones_odd;
    return fail;
  endfunction

endpackage

// File: rtl/yrv_sync_fifo.sv
// Generic show-ahead synchronous FIFO; head visible combinationally, zero when empty.
// Push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module yrv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/yrv_aux_uart_rx.sv
// 16x-oversampling UART receiver with per-character error flags buffered in a show-ahead FIFO.
// Start edge to rx_valid: 3 + (8 + 16*(DATA_BITS+P+1))*(baud_div+1) clk; full FIFO drops and flags overrun.
module yrv_aux_uart_rx
  import yrv_uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 rxd_in,
  input  logic [15:0]          baud_div,
  input  logic                 rx_en,
  input  logic                 rd_en,
  input  logic                 clr_ovr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_perr,
  output logic                 rd_ferr,
  output logic                 rx_valid,
  output logic                 rx_full,
  output logic                 rx_ovr,
  output logic                 rx_busy
);

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic                 fall, start_det, tick, samp_last, sample_now;
  rx_state_e            state_q, state_d;
  logic [15:0]          tick_cnt_q, tick_cnt_d;
  logic [3:0]           samp_cnt_q, samp_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 push, ferr_new;
  logic                 fifo_full, fifo_empty;
  rx_entry_t            entry_in, head;
  logic                 unused_head_data;

  // Idle-high reset values keep reset release from looking like a start edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxd_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign fall       = rx_prev_q & ~rx_s2_q;
  assign start_det  = (state_q == ST_IDLE) & rx_en & fall;
  assign tick       = (tick_cnt_q == baud_div);
  assign tick_cnt_d = (start_det | tick) ? 16'd0 : tick_cnt_q + 16'd1;
  assign samp_last  = (state_q == ST_START) ? (samp_cnt_q == 4'd7) : (samp_cnt_q == 4'd15);
  assign sample_now = tick & samp_last;

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    push       = 1'b0;
    ferr_new   = 1'b0;
    if (tick && !samp_last) samp_cnt_d = samp_cnt_q + 4'd1;
    if (sample_now) samp_cnt_d = 4'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d    = ST_START;
          samp_cnt_d = 4'd0;
          bit_cnt_d  = 4'd0;
          perr_d     = 1'b0;
        end
      end
      ST_START: begin
        if (sample_now) state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample_now) begin
          shift_d   = {rx_s2_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_BITS - 1))
            state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (sample_now) begin
          perr_d  = parity_fail(PARITY_MODE, (^shift_q) ^ rx_s2_q);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_now) begin
          push     = 1'b1;
          ferr_new = ~rx_s2_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling the receiver abandons any character in flight.
    if (!rx_en) begin
      state_d = ST_IDLE;
      push    = 1'b0;
    end
  end

  assign ovr_d = (push & fifo_full & ~rd_en) | (ovr_q & ~clr_ovr);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign entry_in = '{data: RX_MAX_BITS'(shift_q), perr: perr_q, ferr: ferr_new};

  yrv_sync_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (resetb),
    .push_i (push),
    .din_i  (entry_in),
    .pop_i  (rd_en),
    .dout_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign rd_data          = head.data[DATA_BITS-1:0];
  assign unused_head_data = ^head.data;
  assign rd_perr          = head.perr;
  assign rd_ferr          = head.ferr;
  assign rx_valid         = ~fifo_empty;
  assign rx_full          = fifo_full;
  assign rx_ovr           = ovr_q;
  assign rx_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_yrv_aux_uart_rx.sv
// Directed bench for yrv_aux_uart_rx: 8N1/depth-4, 8E1 and 7O1 instances sharing the serial line.
`timescale 1ns/1ps
module tb_yrv_aux_uart_rx;

  logic        clk = 1'b0;
  logic        resetb, rxd, clr_ovr;
  logic [15:0] baud_div;
  logic        rx_en_a, rd_en_a, rx_en_b, rd_en_b, rx_en_c, rd_en_c;

  logic [7:0] rd_data_a, rd_data_b;
  logic [6:0] rd_data_c;
  logic rd_perr_a, rd_ferr_a, rx_valid_a, rx_full_a, rx_ovr_a, rx_busy_a;
  logic rd_perr_b, rd_ferr_b, rx_valid_b, rx_full_b, rx_ovr_b, rx_busy_b;
  logic rd_perr_c, rd_ferr_c, rx_valid_c, rx_full_c, rx_ovr_c, rx_busy_c;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat;
  logic pre_busy;
  logic [7:0] exp_q [4];

  always #5 clk = ~clk;

  yrv_aux_uart_rx #(.DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .resetb(resetb), .rxd_in(rxd), .baud_div(baud_div), .rx_en(rx_en_a),
    .rd_en(rd_en_a), .clr_ovr(clr_ovr), .rd_data(rd_data_a), .rd_perr(rd_perr_a),
    .rd_ferr(rd_ferr_a), .rx_valid(rx_valid_a), .rx_full(rx_full_a), .rx_ovr(rx_ovr_a),
    .rx_busy(rx_busy_a));

  yrv_aux_uart_rx #(.DATA_BITS(8), .PARITY_MODE(1), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .resetb(resetb), .rxd_in(rxd), .baud_div(baud_div), .rx_en(rx_en_b),
    .rd_en(rd_en_b), .clr_ovr(clr_ovr), .rd_data(rd_data_b), .rd_perr(rd_perr_b),
    .rd_ferr(rd_ferr_b), .rx_valid(rx_valid_b), .rx_full(rx_full_b), .rx_ovr(rx_ovr_b),
    .rx_busy(rx_busy_b));

  yrv_aux_uart_rx #(.DATA_BITS(7), .PARITY_MODE(2), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .resetb(resetb), .rxd_in(rxd), .baud_div(baud_div), .rx_en(rx_en_c),
    .rd_en(rd_en_c), .clr_ovr(clr_ovr), .rd_data(rd_data_c), .rd_perr(rd_perr_c),
    .rd_ferr(rd_ferr_c), .rx_valid(rx_valid_c), .rx_full(rx_full_c), .rx_ovr(rx_ovr_c),
    .rx_busy(rx_busy_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // seq[0] is the start bit; one bit per 16*(baud_div+1) clocks. pop_at pulses rd_en_a so
  // that it is sampled on edge pop_at+1; rst_at asserts resetb and returns early.
  task automatic send(input logic [11:0] seq, input int nbits, input int pop_at,
                      input int rst_at, output int lat_o);
    int   per;
    logic v0;
    per   = 16 * (int'(baud_div) + 1);
    lat_o = -1;
    v0    = rx_valid_a;
    for (int c = 0; c < nbits * per; c++) begin
      if (c == rst_at) begin
        pre_busy = rx_busy_a;
        resetb   = 1'b0;
        rxd      = 1'b1;
        rd_en_a  = 1'b0;
        return;
      end
      rxd     = seq[c / per];
      rd_en_a = (c == pop_at);
      @(posedge clk);
      #1;
      if (!v0 && rx_valid_a && lat_o < 0) lat_o = c + 1;
    end
    rxd     = 1'b1;
    rd_en_a = 1'b0;
  endtask

  task automatic pop(input int sel);
    case (sel)
      0:       rd_en_a = 1'b1;
      1:       rd_en_b = 1'b1;
      default: rd_en_c = 1'b1;
    endcase
    @(posedge clk);
    #1;
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
    rd_en_c = 1'b0;
  endtask

  initial begin
    resetb = 1'b0; rxd = 1'b1; baud_div = 16'd0; clr_ovr = 1'b0;
    rx_en_a = 1'b0; rd_en_a = 1'b0; rx_en_b = 1'b0; rd_en_b = 1'b0;
    rx_en_c = 1'b0; rd_en_c = 1'b0;
    cycles(3);
    chk("rst_data",  32'(rd_data_a),  32'h0);
    chk("rst_perr",  32'(rd_perr_a),  32'h0);
    chk("rst_ferr",  32'(rd_ferr_a),  32'h0);
    chk("rst_valid", 32'(rx_valid_a), 32'h0);
    chk("rst_full",  32'(rx_full_a),  32'h0);
    chk("rst_ovr",   32'(rx_ovr_a),   32'h0);
    chk("rst_busy",  32'(rx_busy_a),  32'h0);
    resetb = 1'b1;
    cycles(2);

    // 8N1 0xA5, latency from start edge at baud_div=0
    rx_en_a = 1'b1;
    send(12'({1'b1, 8'hA5, 1'b0}), 10, -1, -1, lat);
    chk("a5_lat_155", 32'(lat >= 154 && lat <= 156), 32'h1);
    chk("a5_data",  32'(rd_data_a),  32'hA5);
    chk("a5_perr",  32'(rd_perr_a),  32'h0);
    chk("a5_ferr",  32'(rd_ferr_a),  32'h0);
    chk("a5_busy",  32'(rx_busy_a),  32'h0);
    pop(0);
    chk("a5_popped", 32'(rx_valid_a), 32'h0);

    // Fill depth-4 FIFO, then push-with-pop while full, then a real overrun
    send(12'({1'b1, 8'h11, 1'b0}), 10, -1, -1, lat);
    send(12'({1'b1, 8'h22, 1'b0}), 10, -1, -1, lat);
    send(12'({1'b1, 8'h33, 1'b0}), 10, -1, -1, lat);
    send(12'({1'b1, 8'h44, 1'b0}), 10, -1, -1, lat);
    chk("fill_full", 32'(rx_full_a), 32'h1);
    chk("fill_ovr",  32'(rx_ovr_a),  32'h0);
    chk("fill_head", 32'(rd_data_a), 32'h11);
    send(12'({1'b1, 8'h55, 1'b0}), 10, 154, -1, lat);
    chk("pushpop_full", 32'(rx_full_a), 32'h1);
    chk("pushpop_ovr",  32'(rx_ovr_a),  32'h0);
    chk("pushpop_head", 32'(rd_data_a), 32'h22);
    send(12'({1'b1, 8'h66, 1'b0}), 10, -1, -1, lat);
    chk("ovr_set",  32'(rx_ovr_a),  32'h1);
    chk("ovr_full", 32'(rx_full_a), 32'h1);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("readback_%0d", i), 32'(rd_data_a), 32'(exp_q[i]));
      pop(0);
    end
    chk("drained_valid", 32'(rx_valid_a), 32'h0);
    chk("drained_full",  32'(rx_full_a),  32'h0);
    chk("ovr_sticky",    32'(rx_ovr_a),   32'h1);
    clr_ovr = 1'b1;
    cycles(1);
    clr_ovr = 1'b0;
    chk("ovr_cleared", 32'(rx_ovr_a), 32'h0);

    // Short low glitch at baud_div=1 is rejected by the start-bit check
    baud_div = 16'd1;
    cycles(2);
    rxd = 1'b0;
    cycles(8);
    chk("glitch_busy", 32'(rx_busy_a), 32'h1);
    rxd = 1'b1;
    cycles(60);
    chk("glitch_idle",  32'(rx_busy_a),  32'h0);
    chk("glitch_empty", 32'(rx_valid_a), 32'h0);

    // Async reset in the middle of DATA, then clean reception of 0x3C
    send(12'({1'b1, 8'h5A, 1'b0}), 10, -1, -1, lat);
    chk("pre_rst_data", 32'(rd_data_a), 32'h5A);
    send(12'({1'b1, 8'h3C, 1'b0}), 10, -1, 128, lat);
    #1;
    chk("pre_rst_busy", 32'(pre_busy),   32'h1);
    chk("arst_busy",    32'(rx_busy_a),  32'h0);
    chk("arst_valid",   32'(rx_valid_a), 32'h0);
    chk("arst_data",    32'(rd_data_a),  32'h0);
    chk("arst_full",    32'(rx_full_a),  32'h0);
    chk("arst_ovr",     32'(rx_ovr_a),   32'h0);
    #5;
    resetb = 1'b1;
    cycles(4);
    send(12'({1'b1, 8'h3C, 1'b0}), 10, -1, -1, lat);
    chk("3c_lat_307", 32'(lat >= 306 && lat <= 308), 32'h1);
    chk("3c_data", 32'(rd_data_a), 32'h3C);
    chk("3c_ferr", 32'(rd_ferr_a), 32'h0);
    pop(0);

    // rx_en dropped mid-character aborts without a push
    baud_div = 16'd0;
    cycles(2);
    rxd = 1'b0;
    cycles(40);
    chk("abort_busy_pre", 32'(rx_busy_a), 32'h1);
    rx_en_a = 1'b0;
    cycles(1);
    chk("abort_busy", 32'(rx_busy_a), 32'h0);
    rxd = 1'b1;
    cycles(200);
    chk("abort_empty", 32'(rx_valid_a), 32'h0);

    // 8E1: 0x03 has two ones, so parity bit 1 is an error and 0 is clean
    rx_en_b = 1'b1;
    send(12'({1'b1, 1'b1, 8'h03, 1'b0}), 11, -1, -1, lat);
    chk("e1_bad_data", 32'(rd_data_b), 32'h03);
    chk("e1_bad_perr", 32'(rd_perr_b), 32'h1);
    chk("e1_bad_ferr", 32'(rd_ferr_b), 32'h0);
    pop(1);
    send(12'({1'b1, 1'b0, 8'h03, 1'b0}), 11, -1, -1, lat);
    chk("e1_ok_data", 32'(rd_data_b), 32'h03);
    chk("e1_ok_perr", 32'(rd_perr_b), 32'h0);
    pop(1);
    send(12'({1'b1, 1'b1, 8'h07, 1'b0}), 11, -1, -1, lat);
    chk("e1_07_perr", 32'(rd_perr_b), 32'h0);
    pop(1);
    chk("e1_empty", 32'(rx_valid_b), 32'h0);
    rx_en_b = 1'b0;

    // 7O1: framing error on 0x55, then clean 0x12, then bad odd parity on 0x12
    rx_en_c = 1'b1;
    send(12'({1'b0, 1'b1, 7'h55, 1'b0}), 10, -1, -1, lat);
    chk("o7_55_data", 32'(rd_data_c), 32'h55);
    chk("o7_55_ferr", 32'(rd_ferr_c), 32'h1);
    chk("o7_55_perr", 32'(rd_perr_c), 32'h0);
    pop(2);
    send(12'({1'b1, 1'b1, 7'h12, 1'b0}), 10, -1, -1, lat);
    chk("o7_12_data", 32'(rd_data_c), 32'h12);
    chk("o7_12_ferr", 32'(rd_ferr_c), 32'h0);
    chk("o7_12_perr", 32'(rd_perr_c), 32'h0);
    pop(2);
    send(12'({1'b1, 1'b0, 7'h12, 1'b0}), 10, -1, -1, lat);
    chk("o7_bad_perr", 32'(rd_perr_c), 32'h1);
    pop(2);
    chk("o7_empty", 32'(rx_valid_c), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
